// File: rtl/prime_candidate_seq.sv
// rtl/prime_candidate_seq.sv - odd candidate builder and search controller feeding miller_rabin
module prime_candidate_seq #(
  parameter int WORDSIZE  = 31,
  parameter int RAND_W    = 16,
  parameter int MAX_TRIES = 1024,
  localparam int NWORDS   = (WORDSIZE + RAND_W - 1) / RAND_W,
  localparam int TRIES_W  = $clog2(MAX_TRIES + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [RAND_W-1:0]   rand_in,
  input  logic                mr_finish,
  input  logic                mr_prime,
  output logic [WORDSIZE-1:0] candidate,
  output logic                mr_reset,
  output logic                busy,
  output logic                prime_valid,
  output logic [WORDSIZE-1:0] prime_out,
  output logic                fail,
  output logic [TRIES_W-1:0]  tries
);

  localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int WIDE_W = NWORDS * RAND_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATHER,
    S_WAIT,
    S_STEP,
    S_DONE,
    S_FAIL
  } state_t;

  state_t              state_q, state_d;
  logic [WORDSIZE-1:0] cand_q, cand_d;
  logic [WORDSIZE-1:0] prime_out_q, prime_out_d;
  logic [TRIES_W-1:0]  tries_q, tries_d;
  logic [WIDX_W-1:0]   widx_q, widx_d;
  logic                mr_reset_q, mr_reset_d;
  logic                prime_valid_q, prime_valid_d;
  logic                fail_q, fail_d;
  logic                blank_q, blank_d;
  logic [WIDE_W-1:0]   wide;

  // State and datapath registers; async reset returns everything to idle with miller_rabin held in reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cand_q        <= '0;
      prime_out_q   <= '0;
      tries_q       <= '0;
      widx_q        <= '0;
      mr_reset_q    <= 1'b1;
      prime_valid_q <= 1'b0;
      fail_q        <= 1'b0;
      blank_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      prime_out_q   <= prime_out_d;
      tries_q       <= tries_d;
      widx_q        <= widx_d;
      mr_reset_q    <= mr_reset_d;
      prime_valid_q <= prime_valid_d;
      fail_q        <= fail_d;
      blank_q       <= blank_d;
    end
  end

  // Next-state logic: gather words, wait for a verdict (ignoring its first cycle), step or finish
  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    prime_out_d   = prime_out_q;
    tries_d       = tries_q;
    widx_d        = widx_q;
    prime_valid_d = 1'b0;
    fail_d        = 1'b0;

    // candidate with the current random word dropped into slot widx_q; bits past WORDSIZE fall off
    wide = '0;
    wide[WORDSIZE-1:0] = cand_q;
    wide[int'(widx_q)*RAND_W +: RAND_W] = rand_in;

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_d = S_GATHER;
          tries_d = '0;
          widx_d  = '0;
        end
      end
      S_GATHER: begin
        cand_d = wide[WORDSIZE-1:0];
        if (widx_q == WIDX_W'(NWORDS - 1)) begin
          cand_d[0]          = 1'b1;
          cand_d[WORDSIZE-1] = 1'b1;
          widx_d             = '0;
          state_d            = S_WAIT;
        end else begin
          widx_d = widx_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (!blank_q && mr_finish) begin
          tries_d = tries_q + 1'b1;
          if (mr_prime) begin
            prime_out_d   = cand_q;
            prime_valid_d = 1'b1;
            state_d       = S_DONE;
          end else if (tries_d == TRIES_W'(MAX_TRIES)) begin
            fail_d  = 1'b1;
            state_d = S_FAIL;
          end else begin
            state_d = S_STEP;
          end
        end
      end
      S_STEP: begin
        if (&cand_q) begin
          widx_d  = '0;
          state_d = S_GATHER;
        end else begin
          cand_d  = cand_q + WORDSIZE'(2);
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    mr_reset_d = (state_d != S_WAIT);
    blank_d    = (state_q != S_WAIT);
  end

  assign candidate   = cand_q;
  assign mr_reset    = mr_reset_q;
  assign busy        = (state_q == S_GATHER) || (state_q == S_WAIT) || (state_q == S_STEP);
  assign prime_valid = prime_valid_q;
  assign prime_out   = prime_out_q;
  assign fail        = fail_q;
  assign tries       = tries_q;

endmodule

// File: tb/tb_prime_candidate_seq.sv
// tb/tb_prime_candidate_seq.sv - randomized and directed checks of prime_candidate_seq against a phase model
module tb_prime_candidate_seq;
  localparam int WS = 31;
  localparam int RW = 16;
  localparam int MT = 4;
  localparam int TW = $clog2(MT + 1);
  localparam int NW = (WS + RW - 1) / RW;
  localparam longint MASK = (64'd1 << WS) - 1;
  localparam longint RMASK = (64'd1 << RW) - 1;

  localparam int P_IDLE = 0, P_GATHER = 1, P_TEST = 2, P_STEP = 3, P_DONE = 4, P_FAIL = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [RW-1:0] rand_in = '0;
  logic mr_finish = 1'b0;
  logic mr_prime = 1'b0;
  logic [WS-1:0] candidate;
  logic mr_reset;
  logic busy;
  logic prime_valid;
  logic [WS-1:0] prime_out;
  logic fail;
  logic [TW-1:0] tries;

  always #5 clk = ~clk;

  prime_candidate_seq #(.WORDSIZE(WS), .RAND_W(RW), .MAX_TRIES(MT)) dut (
    .clk(clk), .reset(reset), .start(start), .rand_in(rand_in),
    .mr_finish(mr_finish), .mr_prime(mr_prime), .candidate(candidate),
    .mr_reset(mr_reset), .busy(busy), .prime_valid(prime_valid),
    .prime_out(prime_out), .fail(fail), .tries(tries)
  );

  // behavioural model: search phase, words collected, cycles spent testing
  int ph, nword, age, m_tries;
  longint m_cand, m_pout;
  bit m_pv, m_fl;
  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    ph = P_IDLE; nword = 0; age = 0; m_tries = 0;
    m_cand = 0; m_pout = 0; m_pv = 0; m_fl = 0;
  endfunction

  function automatic void model_step(bit st, longint rnd, bit fin, bit pr);
    m_pv = 0;
    m_fl = 0;
    case (ph)
      P_IDLE, P_DONE, P_FAIL: if (st) begin ph = P_GATHER; nword = 0; m_tries = 0; end
      P_GATHER: begin
        m_cand = ((m_cand & ~(RMASK << (RW * nword))) | ((rnd & RMASK) << (RW * nword))) & MASK;
        nword++;
        if (nword == NW) begin
          m_cand = m_cand | 1 | (64'd1 << (WS - 1));
          ph = P_TEST;
          age = 0;
        end
      end
      P_TEST: begin
        if (age > 0 && fin) begin
          m_tries++;
          if (pr) begin m_pout = m_cand; m_pv = 1; ph = P_DONE; end
          else if (m_tries == MT) begin m_fl = 1; ph = P_FAIL; end
          else ph = P_STEP;
        end
        age++;
      end
      P_STEP: begin
        if (m_cand == MASK) begin ph = P_GATHER; nword = 0; end
        else begin m_cand = m_cand + 2; ph = P_TEST; age = 0; end
      end
      default: ph = P_IDLE;
    endcase
  endfunction

  // compare every output against the model once per cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("candidate", 64'(candidate), m_cand);
      check("mr_reset", 64'(mr_reset), 64'(ph != P_TEST));
      check("busy", 64'(busy), 64'(ph == P_GATHER || ph == P_TEST || ph == P_STEP));
      check("prime_valid", 64'(prime_valid), 64'(m_pv));
      check("fail", 64'(fail), 64'(m_fl));
      check("tries", 64'(tries), 64'(m_tries));
      check("prime_out", 64'(prime_out), m_pout);
    end
  end

  function automatic logic [RW-1:0] rn();
    return RW'($urandom);
  endfunction

  task automatic cyc(bit st, logic [RW-1:0] rnd, bit fin, bit pr);
    start = st; rand_in = rnd; mr_finish = fin; mr_prime = pr;
    @(posedge clk);
    if (reset) model_reset();
    else model_step(st, longint'(rnd), fin, pr);
    @(negedge clk);
    #1;
  endtask

  // one test from the first WAIT cycle: blank cycle, extra idle cycles, then the verdict
  task automatic test_once(int extra, bit pr);
    cyc(0, rn(), 0, 0);
    repeat (extra) cyc(0, rn(), 0, 0);
    cyc(0, rn(), 1, pr);
  endtask

  task automatic async_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check("arst_candidate", 64'(candidate), 0);
    check("arst_mr_reset", 64'(mr_reset), 1);
    check("arst_busy", 64'(busy), 0);
    check("arst_pulses", 64'({prime_valid, fail}), 0);
    check("arst_tries", 64'(tries), 0);
    check("arst_prime_out", 64'(prime_out), 0);
    cyc(0, rn(), 0, 0);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_candidate", 64'(candidate), 0);
    check("reset_mr_reset", 64'(mr_reset), 1);
    check("reset_busy", 64'(busy), 0);
    check("reset_tries", 64'(tries), 0);
    check("reset_pulses", 64'({prime_valid, fail}), 0);
    chk_en = 1'b1;
    reset = 1'b0;

    // prime on the first candidate
    cyc(1, rn(), 0, 0); cyc(0, 16'hAAA3, 0, 0); cyc(0, 16'h1234, 0, 0);
    check("t1_cand", 64'(candidate), 64'h5234AAA3);
    check("t1_mr_reset_wait", 64'(mr_reset), 0);
    test_once(0, 1);
    check("t1_pv", 64'(prime_valid), 1);
    check("t1_prime_out", 64'(prime_out), 64'h5234AAA3);
    check("t1_tries", 64'(tries), 1);
    cyc(0, rn(), 0, 0);
    check("t1_pv_single", 64'(prime_valid), 0);

    // composite, composite, prime
    cyc(1, rn(), 0, 0); cyc(0, 16'hAAA3, 0, 0); cyc(0, 16'h1234, 0, 0);
    test_once(0, 0); cyc(0, rn(), 0, 0);
    check("t2_cand2", 64'(candidate), 64'h5234AAA5);
    test_once(2, 0); cyc(0, rn(), 0, 0);
    check("t2_cand3", 64'(candidate), 64'h5234AAA7);
    test_once(0, 1);
    check("t2_prime_out", 64'(prime_out), 64'h5234AAA7);
    check("t2_tries", 64'(tries), 3);

    // all-ones candidate forces a fresh gather
    cyc(1, rn(), 0, 0); cyc(0, 16'hFFFF, 0, 0); cyc(0, 16'h7FFF, 0, 0);
    check("t3_cand_ones", 64'(candidate), 64'h7FFFFFFF);
    test_once(0, 0); cyc(0, rn(), 0, 0);
    check("t3_regather_busy", 64'({busy, mr_reset}), 64'h3);
    cyc(0, 16'h1111, 0, 0); cyc(0, 16'h2222, 0, 0);
    check("t3_cand_new", 64'(candidate), 64'h62221111);
    test_once(0, 1);
    check("t3_prime_out", 64'(prime_out), 64'h62221111);
    check("t3_tries", 64'(tries), 2);

    // try budget exhaustion
    cyc(1, rn(), 0, 0); cyc(0, 16'h0001, 0, 0); cyc(0, 16'h0000, 0, 0);
    for (int i = 0; i < MT - 1; i++) begin
      test_once(0, 0);
      cyc(0, rn(), 0, 0);
    end
    test_once(0, 0);
    check("t4_fail", 64'(fail), 1);
    check("t4_no_pv", 64'(prime_valid), 0);
    check("t4_busy", 64'(busy), 0);
    check("t4_tries", 64'(tries), MT);
    cyc(0, rn(), 0, 0);
    check("t4_fail_single", 64'(fail), 0);

    // stale finish held high into WAIT
    cyc(1, rn(), 1, 1); cyc(0, rn(), 1, 1); cyc(0, rn(), 1, 1);
    cyc(0, rn(), 1, 1);
    check("t5_blank_tries", 64'(tries), 0);
    check("t5_blank_pv", 64'(prime_valid), 0);
    cyc(0, rn(), 1, 1);
    check("t5_tries", 64'(tries), 1);
    check("t5_pv", 64'(prime_valid), 1);

    // start while busy, start with finish, then reset mid-WAIT
    cyc(1, rn(), 0, 0); cyc(1, 16'h0003, 0, 0); cyc(1, 16'h0000, 0, 0);
    cyc(1, rn(), 0, 0);
    check("t6_start_busy_cand", 64'(candidate), 64'h40000003);
    check("t6_start_busy_tries", 64'(tries), 0);
    cyc(1, rn(), 1, 0);
    check("t6_start_fin_tries", 64'(tries), 1);
    check("t6_start_fin_busy", 64'(busy), 1);
    cyc(0, rn(), 0, 0);
    check("t6_step_cand", 64'(candidate), 64'h40000005);
    cyc(0, rn(), 0, 0);
    async_reset();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 3) async_reset();
      else cyc($urandom_range(0, 7) == 0, ($urandom_range(0, 3) == 0) ? 16'hFFFF : rn(),
               $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
